btn_frontend: RTL and testbench
===============================

# btn_frontend

Parametrised board-input front end: N push-button channels pass through a synchroniser, a shared sample-tick prescaler and a per-channel debouncer. Each channel produces a clean level plus single-cycle rise and fall pulses. Everything runs in one clock domain, with the tick used as a clock enable, so no divided clock is needed. The block sits between the raw board buttons and the game logic, and replaces the separate clock divider plus the per-button debouncer instances.

## Interface
- `N_BTN`, 4, number of button channels
- `TICK_DIV`, 250000, `clk` cycles per sample tick; must be ≥1
- `STABLE_TICKS`, 4, consecutive disagreeing ticks required to change a level; must be ≥1
- `SYNC_STAGES`, 2, synchroniser flop depth; must be ≥2
- `HOLD_TICKS`, 500, ticks of continuous press before `btn_hold` fires; used only with the macro
- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-high reset
- `btn` in `N_BTN`: raw asynchronous button inputs, 1 = pressed
- `btn_level` out `N_BTN`: debounced level
- `btn_rise` out `N_BTN`: one-cycle pulse on a debounced press
- `btn_fall` out `N_BTN`: one-cycle pulse on a debounced release
- `btn_hold` out `N_BTN`: one-cycle long-press pulse; constant 0 without the macro
- `tick` out 1: prescaler strobe, exposed so downstream logic can share it

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per channel, all reset to 0. The last stage is `samp[i]`.
- **Prescaler:** counter `pc` of width `$clog2(TICK_DIV)`, minimum 1 bit.
  - `tick` = 1 exactly when `pc == TICK_DIV-1`. On that cycle `pc` wraps to 0; otherwise `pc` increments.
  - With `TICK_DIV = 1`, `tick` is 1 on every cycle.
- **Per-channel debouncer:** counter `sc` of width `$clog2(STABLE_TICKS+1)`. It is evaluated only on tick cycles; between ticks `sc` and `btn_level` hold.
  - If `samp == btn_level`: `sc <= 0`.
  - Else if `sc == STABLE_TICKS-1`: `btn_level <= samp` and `sc <= 0`.
  - Else: `sc <= sc + 1`.
- **Edge pulses:** `btn_rise` / `btn_fall` are registered alongside the level update. They are high for exactly the first cycle in which the new `btn_level` is visible, and for no other cycle.
- **Channel independence:** channels never interact. Simultaneous edges on several channels produce pulses in the same cycle.
- **Button held through reset:** the level leaves reset at 0 regardless of `btn`. After release it rises after a normal debounce and emits `btn_rise`. This is intended behaviour.
- **Reset mid-debounce:** all partial counts are discarded and no pulse is emitted.

## Timing
- **Reset values:** every output 0. `pc`, `sc`, synchroniser flops and hold counters are all 0.
- **Input latency:** a `btn` change reaches `samp` after `SYNC_STAGES` cycles.
- **Level latency:** `btn_level` changes on the `STABLE_TICKS`-th consecutive tick that samples the new value.
  - Worst case from the input edge: `SYNC_STAGES + STABLE_TICKS*TICK_DIV` cycles.
  - Best case: `SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1` cycles.
- **Glitch rejection:** a pulse shorter than `(STABLE_TICKS-1)*TICK_DIV` cycles never changes the level.
- **Pulse width:** `btn_rise`, `btn_fall` and `btn_hold` are each exactly 1 `clk` cycle wide. `tick` is 1 cycle wide every `TICK_DIV` cycles.
- **Reset priority:** `rst` wins over `tick` in the same cycle.

## Configuration
- **Macro:** `BTN_FRONTEND_HOLD_EN`.
- **Defined:** each channel gets a hold counter. It increments on ticks while `btn_level = 1`, saturating at `HOLD_TICKS`.
  - `btn_hold[i]` pulses once, in the cycle the counter reaches `HOLD_TICKS`.
  - The counter clears when `btn_level` returns to 0.
  - There is no auto-repeat: one hold pulse per press.
- **Undefined:** no hold counters are built, `btn_hold` is tied to 0, and `HOLD_TICKS` is ignored.

## Structure
- **Package `btn_frontend_pkg`:**
  - default parameter constants;
  - a `cnt_w(n)` width function (`$clog2` with minimum 1);
  - the channel status struct {level, rise, fall, hold}.
- **Sub-module `btn_debounce_ch`:** synchroniser, stable counter, edge pulses and optional hold counter for one channel. Instantiated `N_BTN` times in a generate loop, all sharing the top-level prescaler `tick`.

## Test plan
Bench parameters unless noted: `N_BTN = 4`, `TICK_DIV = 4`, `SYNC_STAGES = 2`, `STABLE_TICKS = 3`.

1. **Reset with buttons held:** `btn = 4'hF` held, `rst` high for 5 cycles.
   - During reset all outputs are 0.
   - After release, `btn_rise = 4'hF` for exactly one cycle within 14 cycles, then `btn_level = 4'hF`.
2. **Glitch rejection:** `btn[0]` high for 6 cycles, then low.
   - `btn_level`, `btn_rise` and `btn_fall` stay 0 throughout.
3. **Clean press/release on `btn[1]`:** high for 30 cycles, then low.
   - Exactly one `btn_rise[1]` pulse and one `btn_fall[1]` pulse.
   - Each follows its input edge by 11 to 14 cycles.
   - `btn_level[1]` is high between the two pulses.
4. **Simultaneous press:** `btn[3]` and `btn[2]` rise in the same cycle.
   - `btn_rise == 4'b1100` in a single cycle; channels 0 and 1 are unaffected.
5. **Reset mid-debounce:** `btn[0]` held high; `rst` pulsed after the second qualifying tick.
   - No `btn_rise[0]` before or during reset.
   - After reset, the rise appears only after 3 fresh ticks.
6. **Hold, with `BTN_FRONTEND_HOLD_EN` and `HOLD_TICKS = 5`:** `btn[0]` held for 60 cycles.
   - Exactly one `btn_hold[0]` pulse, 20 cycles after `btn_rise[0]`.
   - Rebuilt without the macro: `btn_hold == 0` throughout.

Source files
------------

// File: rtl/btn_frontend_pkg.sv
// Shared constants, width helper and channel status payload for btn_frontend.
package btn_frontend_pkg;

  localparam int unsigned DEF_N_BTN        = 4;
  localparam int unsigned DEF_TICK_DIV     = 250000;
  localparam int unsigned DEF_STABLE_TICKS = 4;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_HOLD_TICKS   = 500;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Per-channel result as seen by the game logic.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic hold;
  } btn_status_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, tick-gated stable counter, edge pulses and
// an optional long-press counter built only when BTN_FRONTEND_HOLD_EN is defined.
module btn_debounce_ch
  import btn_frontend_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn,
  output btn_status_t status
);

  localparam int unsigned SC_W = cnt_w(STABLE_TICKS + 32'd1);

  if (STABLE_TICKS < 1 || SYNC_STAGES < 2 || HOLD_TICKS < 1) begin : g_param_check
    $error("btn_debounce_ch: STABLE_TICKS>=1, SYNC_STAGES>=2, HOLD_TICKS>=1 required");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   samp;
  logic [SC_W-1:0]        sc;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   hold_q;

  assign samp   = sync[SYNC_STAGES-1];
  assign status = {level_q, rise_q, fall_q, hold_q};

  // Metastability shift chain; oldest stage feeds the debouncer.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn};
  end

  // Count consecutive disagreeing ticks; commit the level and pulse on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc      <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (tick) begin
        if (samp == level_q) begin
          sc <= '0;
        end else if (sc == SC_W'(STABLE_TICKS - 32'd1)) begin
          level_q <= samp;
          rise_q  <= samp;
          fall_q  <= ~samp;
          sc      <= '0;
        end else begin
          sc <= sc + SC_W'(1);
        end
      end
    end
  end

`ifdef BTN_FRONTEND_HOLD_EN
  localparam int unsigned HC_W = cnt_w(HOLD_TICKS + 32'd1);
  logic [HC_W-1:0] hc;

  // Long-press timer: saturates so only one pulse is emitted per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc     <= '0;
      hold_q <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (!level_q) begin
        hc <= '0;
      end else if (tick && (hc != HC_W'(HOLD_TICKS))) begin
        hc     <= hc + HC_W'(1);
        hold_q <= (hc == HC_W'(HOLD_TICKS - 32'd1));
      end
    end
  end
`else
  assign hold_q = 1'b0;
`endif

endmodule

// File: rtl/btn_frontend.sv
// Board button front end: shared sample-tick prescaler plus N debounced channels.
// Long-press detection is compiled in with BTN_FRONTEND_HOLD_EN.
module btn_frontend
  import btn_frontend_pkg::*;
#(
  parameter int unsigned N_BTN        = DEF_N_BTN,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_hold,
  output logic             tick
);

  localparam int unsigned PC_W = cnt_w(TICK_DIV);

  if (TICK_DIV < 1 || N_BTN < 1) begin : g_param_check
    $error("btn_frontend: TICK_DIV>=1 and N_BTN>=1 required");
  end

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;

  // Prescaler advance with wrap on the terminal count.
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pc == PC_W'(TICK_DIV - 32'd1)) pc_next = '0;
  end

  // Tick is registered from the next count so it is high exactly while pc is terminal.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      tick <= 1'b0;
    end else begin
      pc   <= pc_next;
      tick <= (pc_next == PC_W'(TICK_DIV - 32'd1));
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_status_t st;

    btn_debounce_ch #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .HOLD_TICKS   (HOLD_TICKS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .btn    (btn[i]),
      .status (st)
    );

    assign btn_level[i] = st.level;
    assign btn_rise[i]  = st.rise;
    assign btn_fall[i]  = st.fall;
    assign btn_hold[i]  = st.hold;
  end

endmodule

// File: tb/tb_btn_frontend.sv
// Self-checking bench for btn_frontend: directed scenarios with literal
// expectations plus a randomized phase against a cycle-level behavioural model.
module tb_btn_frontend;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned HT = 5;

`ifdef BTN_FRONTEND_HOLD_EN
  localparam int EXP_HOLDS = 1;
`else
  localparam int EXP_HOLDS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic [N-1:0] btn_hold;
  logic         tick;

  int n_cmp = 0;
  int n_bad = 0;

  btn_frontend #(
    .N_BTN        (N),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .SYNC_STAGES  (SS),
    .HOLD_TICKS   (HT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_hold  (btn_hold),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Behavioural model state: what each output must show after the latest edge.
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;
  logic [N-1:0] m_hold  = '0;
  logic         m_tick  = 1'b0;
  bit           m_valid = 1'b0;
  logic [N-1:0] dly [SS];
  int           run [N];
  int           nsr = 0;
`ifdef BTN_FRONTEND_HOLD_EN
  int           hcnt [N];
`endif

  // Model: samp is btn delayed SS edges; ticks every TD edges after reset;
  // a level flips after ST consecutive ticks sampling the opposite value.
  always @(posedge clk) begin : model
    logic [N-1:0] samp;
    logic         tk;
    samp = dly[SS-1];
    tk   = ((nsr % TD) == TD - 1);
    if (rst) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_hold = '0;
      for (int k = 0; k < SS; k++) dly[k] = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
`ifdef BTN_FRONTEND_HOLD_EN
        hcnt[i] = 0;
`endif
      end
      nsr     = 0;
      m_valid = 1'b1;
    end else begin
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int i = 0; i < N; i++) begin
`ifdef BTN_FRONTEND_HOLD_EN
        if (!m_level[i]) hcnt[i] = 0;
        else if (tk && hcnt[i] < HT) begin
          hcnt[i]++;
          if (hcnt[i] == HT) m_hold[i] = 1'b1;
        end
`endif
        if (tk) begin
          if (samp[i] == m_level[i]) run[i] = 0;
          else begin
            run[i]++;
            if (run[i] == ST) begin
              m_level[i] = samp[i];
              m_rise[i]  = samp[i];
              m_fall[i]  = ~samp[i];
              run[i]     = 0;
            end
          end
        end
      end
      for (int k = SS - 1; k > 0; k--) dly[k] = dly[k-1];
      dly[0] = btn;
      nsr++;
    end
    m_tick = ((nsr % TD) == TD - 1);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if ({btn_level, btn_rise, btn_fall, btn_hold, tick} !==
          {m_level, m_rise, m_fall, m_hold, m_tick}) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t got lvl=%h rise=%h fall=%h hold=%h tick=%b expected lvl=%h rise=%h fall=%h hold=%h tick=%b",
                 $time, btn_level, btn_rise, btn_fall, btn_hold, tick,
                 m_level, m_rise, m_fall, m_hold, m_tick);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic settle(input logic [N-1:0] v);
    btn = v;
    repeat (40) @(negedge clk);
  endtask

  // Called at the negedge where rst was just lowered: rise must land on edge 12.
  task automatic expect_rise_after_reset(input logic [N-1:0] mask);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("rst_no_early_rise", 32'(btn_rise & mask), 32'd0);
    end
    @(negedge clk);
    chk("rst_rise", 32'(btn_rise & mask), 32'(mask));
    chk("rst_level", 32'(btn_level & mask), 32'(mask));
    @(negedge clk);
    chk("rst_rise_one_cycle", 32'(btn_rise & mask), 32'd0);
    chk("rst_level_kept", 32'(btn_level & mask), 32'(mask));
  endtask

  initial begin : stim
    int nr, nf, tr, tf, q, nh, th;

    // 1: reset with every button held.
    rst = 1'b1;
    btn = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("reset_outputs_zero", 32'({btn_level, btn_rise, btn_fall, btn_hold, tick}), 32'd0);
    end
    rst = 1'b0;
    expect_rise_after_reset(4'hF);

    // 2: glitch on channel 0 shorter than the debounce window.
    settle('0);
    btn[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("glitch_quiet", 32'({btn_level[0], btn_rise[0], btn_fall[0]}), 32'd0);
      if (k == 6) btn[0] = 1'b0;
    end

    // 3: clean press/release on channel 1.
    nr = 0; nf = 0; tr = -1; tf = -1;
    btn[1] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (btn_rise[1]) begin nr++; tr = k; end
      if (btn_fall[1]) begin nf++; tf = k; end
      if (tr > 0 && tf < 0) chk("press_level_high", 32'(btn_level[1]), 32'd1);
      if (k == 30) btn[1] = 1'b0;
    end
    chk("press_rise_count", 32'(nr), 32'd1);
    chk("press_fall_count", 32'(nf), 32'd1);
    chk("press_rise_latency_11_14", 32'(tr >= 11 && tr <= 14), 32'd1);
    chk("press_fall_latency_11_14", 32'((tf - 30) >= 11 && (tf - 30) <= 14), 32'd1);
    chk("press_level_low_after", 32'(btn_level[1]), 32'd0);

    // 4: simultaneous press on channels 3 and 2.
    settle('0);
    btn[3:2] = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (btn_rise != '0) break;
    end
    chk("simul_rise", 32'(btn_rise), 32'hC);
    @(negedge clk);
    chk("simul_rise_one_cycle", 32'(btn_rise), 32'd0);
    chk("simul_level", 32'(btn_level), 32'hC);

    // 5: reset after the second qualifying tick on channel 0.
    settle('0);
    btn[0] = 1'b1;
    q = 0;
    for (int k = 1; k <= 40 && q < 2; k++) begin
      @(negedge clk);
      chk("midrst_no_early_rise", 32'(btn_rise[0]), 32'd0);
      if (k >= 2 && tick) q++;
    end
    @(negedge clk);
    chk("midrst_two_ticks_seen", 32'(q), 32'd2);
    chk("midrst_no_rise_before_rst", 32'(btn_rise[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_rise_in_rst", 32'({btn_rise[0], btn_level[0]}), 32'd0);
    rst = 1'b0;
    expect_rise_after_reset(4'b0001);

    // 6: long press on channel 0.
    settle('0);
    btn[0] = 1'b1;
    tr = -1; th = -1; nh = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (btn_rise[0]) tr = k;
      if (btn_hold[0]) begin nh++; th = k; end
      if (k == 60) btn[0] = 1'b0;
    end
    chk("hold_count", 32'(nh), 32'(EXP_HOLDS));
`ifdef BTN_FRONTEND_HOLD_EN
    chk("hold_after_rise_20", 32'(th - tr), 32'd20);
`endif

    // Randomized traffic with occasional resets, checked by the model.
    settle('0);
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
      btn = btn ^ N'($urandom());
      repeat ($urandom_range(1, 28)) @(negedge clk);
    end
    settle('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
